// File: rtl/game_pkg.sv
// Shared state encodings, strobe decoding and frame sequencing for the game controller.
package game_pkg;

    typedef enum logic [3:0] {
        S_INIT         = 4'd0,
        S_DRAW_MAP     = 4'd1,
        S_DRAW_LINK    = 4'd2,
        S_DRAW_ENEMIES = 4'd3,
        S_IDLE         = 4'd4,
        S_GEN_MOVE     = 4'd5,
        S_COLLIDE      = 4'd6,
        S_APPLY        = 4'd7,
        S_MOVE_EN      = 4'd8
    } state_t;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam int NUM_STROBES = 9;

    // Bit i of the strobe vector belongs to the state encoded as i.
    function automatic logic [NUM_STROBES-1:0] strobe_of(input state_t s);
        strobe_of = 9'b1 << s;
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            S_INIT:         next_of = S_DRAW_MAP;
            S_DRAW_MAP:     next_of = S_DRAW_LINK;
            S_DRAW_LINK:    next_of = S_DRAW_ENEMIES;
            S_DRAW_ENEMIES: next_of = S_IDLE;
            S_IDLE:         next_of = S_GEN_MOVE;
            S_GEN_MOVE:     next_of = S_COLLIDE;
            S_COLLIDE:      next_of = S_APPLY;
            S_APPLY:        next_of = S_MOVE_EN;
            S_MOVE_EN:      next_of = S_DRAW_MAP;
            default:        next_of = S_INIT;
        endcase
    endfunction

endpackage

// File: rtl/game_control_watchdog.sv
// Saturating dwell counter: expire is high while enabled on the LIMIT-th cycle since the last clear.
module ctrl_watchdog #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/game_control.sv
// Per-frame game sequencer: drives one-hot phase strobes to the datapath and waits on its done inputs.
module game_control
    import game_pkg::*;
#(
    parameter int unsigned  COLLIDE_CYCLES = 4,
    parameter logic [19:0]  DRAW_TIMEOUT   = 20'd131072,
    parameter int           FRAME_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               idle_done,
    input  logic               draw_map_done,
    input  logic               draw_link_done,
    input  logic               draw_enemies_done,
    output logic               init,
    output logic               idle,
    output logic               gen_move,
    output logic               check_collide,
    output logic               apply_act_link,
    output logic               move_enemies,
    output logic               draw_map,
    output logic               draw_link,
    output logic               draw_enemies,
    output logic               draw_timeout_err,
    output logic [FRAME_W-1:0] frame_count,
    output logic [3:0]         state_dbg
);

    // Handshake: a strobe stays high for the whole phase; the matching done is a level the
    // datapath raises when finished, honoured only from the second cycle of the phase on.
    state_t                 state, nxt;
    logic                   run, first_cyc;
    logic [NUM_STROBES-1:0] strobes;
    logic                   is_draw, done_sel, done_ok, advance, timed_out;
    logic                   draw_expire, coll_expire;

    ctrl_watchdog #(.LIMIT(DRAW_TIMEOUT)) u_draw_wd (
        .clock (clock),
        .reset (reset),
        .clear (advance),
        .enable(is_draw),
        .expire(draw_expire)
    );

    ctrl_watchdog #(.LIMIT(COLLIDE_CYCLES)) u_coll_wd (
        .clock (clock),
        .reset (reset),
        .clear (advance),
        .enable(state == S_COLLIDE),
        .expire(coll_expire)
    );

    always_comb begin
        is_draw  = (state == S_DRAW_MAP) || (state == S_DRAW_LINK) || (state == S_DRAW_ENEMIES);
        done_sel = OFF;
        case (state)
            S_DRAW_MAP:     done_sel = draw_map_done;
            S_DRAW_LINK:    done_sel = draw_link_done;
            S_DRAW_ENEMIES: done_sel = draw_enemies_done;
            S_IDLE:         done_sel = idle_done;
            default:        done_sel = OFF;
        endcase
        done_ok   = done_sel && !first_cyc;
        timed_out = is_draw && draw_expire && !done_ok;
        case (state)
            S_INIT:                                  advance = run;
            S_DRAW_MAP, S_DRAW_LINK, S_DRAW_ENEMIES: advance = done_ok || draw_expire;
            S_IDLE:                                  advance = done_ok;
            S_COLLIDE:                               advance = coll_expire;
            default:                                 advance = ON;
        endcase
        nxt = advance ? next_of(state) : state;
    end

    // The first cycle after reset release is spent in S_INIT with init high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_INIT;
            run              <= OFF;
            first_cyc        <= OFF;
            strobes          <= '0;
            draw_timeout_err <= OFF;
            frame_count      <= '0;
        end else begin
            run       <= ON;
            first_cyc <= advance;
            state     <= nxt;
            strobes   <= strobe_of(nxt);
            if (timed_out) begin
                draw_timeout_err <= ON;
            end
            if ((state == S_DRAW_ENEMIES) && advance) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
        end
    end

    assign {move_enemies, apply_act_link, check_collide, gen_move, idle,
            draw_enemies, draw_link, draw_map, init} = strobes;
    assign state_dbg = state;

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: per-frame done-delay vectors, state dwell scoreboard, reset and wrap sequences.
module tb_game_control;
    import game_pkg::*;

    localparam int FW = 8;

    logic          clock = 0;
    logic          reset = 0;
    logic          idle_done = 0, draw_map_done = 0, draw_link_done = 0, draw_enemies_done = 0;
    logic          init, idle, gen_move, check_collide, apply_act_link, move_enemies;
    logic          draw_map, draw_link, draw_enemies, draw_timeout_err;
    logic [FW-1:0] frame_count;
    logic [3:0]    state_dbg;
    logic [8:0]    strobes;

    game_control #(.COLLIDE_CYCLES(2), .DRAW_TIMEOUT(20'd16), .FRAME_W(FW)) dut (
        .clock            (clock),
        .reset            (reset),
        .idle_done        (idle_done),
        .draw_map_done    (draw_map_done),
        .draw_link_done   (draw_link_done),
        .draw_enemies_done(draw_enemies_done),
        .init             (init),
        .idle             (idle),
        .gen_move         (gen_move),
        .check_collide    (check_collide),
        .apply_act_link   (apply_act_link),
        .move_enemies     (move_enemies),
        .draw_map         (draw_map),
        .draw_link        (draw_link),
        .draw_enemies     (draw_enemies),
        .draw_timeout_err (draw_timeout_err),
        .frame_count      (frame_count),
        .state_dbg        (state_dbg)
    );

    assign strobes = {move_enemies, apply_act_link, check_collide, gen_move, idle,
                      draw_enemies, draw_link, draw_map, init};

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- vectors / scoreboard state ----------------
    // md..id: cycle index within the state at which the done input is raised for one cycle.
    // dm..di: expected dwell of each state; to: the frame contains a timeout.
    typedef struct {
        int md, ld, ed, id;
        int dm, dl, de, di;
        bit to;
    } vec_t;

    vec_t          vecs[8];
    logic [19:0]   exp_q[$];
    int            n_cmp = 0, n_bad = 0;
    int            cfg_m, cfg_l, cfg_e, cfg_i;
    bit            mon_en = 0, have_prev = 0, hold_map = 0, stray = 0;
    logic [3:0]    prev_s;
    int            idx = 0;
    int            frames_seen = 0;
    logic [FW-1:0] exp_frames;
    bit            exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] item(input state_t s, input int d);
        return {s, 16'(d)};
    endfunction

    // ---------------- monitor + done responder ----------------
    always @(negedge clock) begin : mon
        logic [3:0]  cur;
        logic [19:0] got;
        if (mon_en) begin
            cur = state_dbg;
            check("strobe_onehot", 32'(strobes), 32'(9'b1 << cur));
            if (!have_prev) begin
                have_prev = 1;
                prev_s    = cur;
                idx       = 0;
            end else if (cur != prev_s) begin
                got = {prev_s, 16'(idx + 1)};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got visit 0x%0h required none", got);
                end else begin
                    check("dwell", 32'(got), 32'(exp_q.pop_front()));
                end
                if (prev_s == S_MOVE_EN && cur == S_DRAW_MAP) frames_seen++;
                prev_s = cur;
                idx    = 0;
            end else begin
                idx++;
            end
            draw_map_done     = hold_map || (cur == S_DRAW_MAP && idx == cfg_m);
            draw_link_done    = (cur == S_DRAW_LINK && idx == cfg_l) || (stray && cur == S_IDLE);
            draw_enemies_done = (cur == S_DRAW_ENEMIES && idx == cfg_e) || (stray && cur == S_DRAW_MAP);
            idle_done         = (cur == S_IDLE && idx == cfg_i) ||
                                (stray && (cur == S_GEN_MOVE || cur == S_COLLIDE));
        end else begin
            draw_map_done     = hold_map;
            draw_link_done    = 0;
            draw_enemies_done = 0;
            idle_done         = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load(input int v);
        cfg_m = vecs[v].md;
        cfg_l = vecs[v].ld;
        cfg_e = vecs[v].ed;
        cfg_i = vecs[v].id;
        exp_q.push_back(item(S_DRAW_MAP,     vecs[v].dm));
        exp_q.push_back(item(S_DRAW_LINK,    vecs[v].dl));
        exp_q.push_back(item(S_DRAW_ENEMIES, vecs[v].de));
        exp_q.push_back(item(S_IDLE,         vecs[v].di));
        exp_q.push_back(item(S_GEN_MOVE,     1));
        exp_q.push_back(item(S_COLLIDE,      2));
        exp_q.push_back(item(S_APPLY,        1));
        exp_q.push_back(item(S_MOVE_EN,      1));
    endtask

    // Called between clock edges; reset is asynchronous so outputs must clear at once.
    task automatic do_reset();
        #3 reset = 1;
        mon_en    = 0;
        have_prev = 0;
        #1;
        check("rst_strobes", 32'(strobes), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_INIT));
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_timeout_err", 32'(draw_timeout_err), 32'd0);
        exp_q.delete();
        exp_q.push_back(item(S_INIT, 1));
        exp_frames = '0;
        exp_err    = 0;
    endtask

    task automatic run_frames(input int first, input int span, input int n);
        int seen;
        int v;
        bit ok;
        load(first);
        if (reset) begin
            @(posedge clock);
            #2 reset = 0;
            @(posedge clock);
            #1 mon_en = 1;
        end
        for (int k = 0; k < n; k++) begin
            v    = first + (k % span);
            seen = frames_seen;
            ok   = 0;
            for (int t = 0; t < 300; t++) begin
                @(posedge clock);
                if (frames_seen != seen) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_timeout: got no frame end in 300 cycles, required one (frame %0d)", k);
                mon_en = 0;
                return;
            end
            if (k + 1 < n) load(first + ((k + 1) % span));
            @(negedge clock);
            #1;
            exp_frames++;
            exp_err |= vecs[v].to;
            check("frame_count", 32'(frame_count), 32'(exp_frames));
            check("timeout_err", 32'(draw_timeout_err), 32'(exp_err));
        end
        mon_en = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit reached;
        vecs[0] = '{5, 5, 5, 10,   6, 6, 6, 11,    1'b0};
        vecs[1] = '{1, 1, 1, 1,    2, 2, 2, 2,     1'b0};
        vecs[2] = '{15, 3, 7, 2,   16, 4, 8, 3,    1'b0};
        vecs[3] = '{2, 14, 1, 20,  3, 15, 2, 21,   1'b0};
        vecs[4] = '{40, 1, 1, 1,   16, 2, 2, 2,    1'b1};
        vecs[5] = '{1, 16, 1, 3,   2, 16, 2, 4,    1'b1};
        vecs[6] = '{99, 99, 99, 2, 16, 16, 16, 3,  1'b1};
        vecs[7] = '{0, 3, 4, 2,    2, 4, 5, 3,     1'b0};

        repeat (2) @(negedge clock);
        do_reset();
        run_frames(0, 6, 6);

        // Async reset in the middle of S_DRAW_LINK, with a nonzero frame count and error set.
        reached = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            if (state_dbg == S_DRAW_LINK) begin
                reached = 1;
                break;
            end
        end
        check("reach_draw_link", 32'(reached), 32'd1);
        do_reset();

        // All dones low from reset: every draw phase times out.
        run_frames(6, 1, 1);

        // draw_map_done held high plus stray dones in non-matching states.
        @(negedge clock);
        do_reset();
        hold_map = 1;
        stray    = 1;
        run_frames(7, 1, 2);
        hold_map = 0;
        stray    = 0;

        // Fast frames across the frame_count wrap.
        @(negedge clock);
        do_reset();
        run_frames(1, 1, (1 << FW));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL global_timeout: got no end of test, required finish before %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Top-level game FSM; initiator side of the datapath's control/done handshake.
- Sequences the per-frame phases init, draw, idle, move, collide, apply and enemy move by driving one-hot phase strobes to the datapath.
- Consumes the datapath's idle_done, draw_map_done, draw_link_done and draw_enemies_done.
- Adds a per-draw-phase watchdog, a frame counter and a state debug output.

Parameters:
- COLLIDE_CYCLES, 4, cycles check_collide is held high (1..15).
- DRAW_TIMEOUT, 20'd131072, max cycles in any draw state before forced advance.
- FRAME_W, 16, frame_count width.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- idle_done  in  1  frame-period tick from datapath
- draw_map_done  in  1  map draw complete
- draw_link_done  in  1  link draw complete
- draw_enemies_done  in  1  enemy draw complete
- init  out  1  initialise datapath registers
- idle  out  1  idle phase
- gen_move  out  1  latch user/enemy movement request
- check_collide  out  1  collision evaluation enable
- apply_act_link  out  1  apply link action
- move_enemies  out  1  apply enemy movement
- draw_map  out  1  map draw enable
- draw_link  out  1  link draw enable
- draw_enemies  out  1  enemy draw enable
- draw_timeout_err  out  1  sticky: any draw phase timed out
- frame_count  out  FRAME_W  completed frames, wraps
- state_dbg  out  4  current state encoding

Behaviour:
- Outputs are Moore-registered, decoded from state. At most one of the nine phase strobes is high in any cycle.
- Reset (async, any time, including mid-draw):
  - state goes to S_INIT.
  - All strobes go to 0.
  - draw_timeout_err=0, frame_count=0.
  - Watchdog counter is cleared.
- States (encoding, strobe held high):
  - S_INIT 0 (init)
  - S_DRAW_MAP 1 (draw_map)
  - S_DRAW_LINK 2 (draw_link)
  - S_DRAW_ENEMIES 3 (draw_enemies)
  - S_IDLE 4 (idle)
  - S_GEN_MOVE 5 (gen_move)
  - S_COLLIDE 6 (check_collide)
  - S_APPLY 7 (apply_act_link)
  - S_MOVE_EN 8 (move_enemies)
- Transitions:
  - S_INIT goes to S_DRAW_MAP unconditionally; first cycle after reset release.
  - S_DRAW_MAP goes to S_DRAW_LINK on draw_map_done or timeout.
  - S_DRAW_LINK goes to S_DRAW_ENEMIES on draw_link_done or timeout.
  - S_DRAW_ENEMIES goes to S_IDLE on draw_enemies_done or timeout; frame_count increments on that transition.
  - S_IDLE goes to S_GEN_MOVE on idle_done.
  - S_GEN_MOVE goes to S_COLLIDE after exactly 1 cycle.
  - S_COLLIDE goes to S_APPLY after exactly COLLIDE_CYCLES cycles.
  - S_APPLY goes to S_MOVE_EN after 1 cycle.
  - S_MOVE_EN goes to S_DRAW_MAP after 1 cycle.
- Done arming: in the first cycle of every draw state, and of S_IDLE, the done input is ignored. This protects against stale done from the previous frame. Minimum dwell in each of these states is therefore 2 cycles.
- Watchdog, per draw state:
  - Counter clears on state entry and increments each cycle in the state.
  - When the counter reaches DRAW_TIMEOUT-1 without done, the state advances next cycle as if done were seen.
  - draw_timeout_err is set and held until reset.
  - Done and timeout arriving in the same cycle count as done; the error flag is not set.
- Done inputs are ignored in all non-matching states; e.g. draw_link_done high during S_DRAW_MAP has no effect.
- idle_done is honoured only in S_IDLE (after the arming cycle).
- frame_count wraps from all-ones to 0 silently.
- Steady-state frame latency excluding draw/idle dwell: 3 + COLLIDE_CYCLES cycles from leaving S_IDLE to entering S_DRAW_MAP.

Decomposition:
- Shared package game_pkg:
  - State encodings S_INIT..S_MOVE_EN (4-bit localparams), exported for state_dbg decoding in benches.
  - ON/OFF constants.
- One sub-module, ctrl_watchdog: counter with clear/enable inputs, parameterised limit, 1-bit expire output. It is reused for COLLIDE_CYCLES dwell counting (second instance, limit COLLIDE_CYCLES).

Test Plan (DRAW_TIMEOUT=16, COLLIDE_CYCLES=2):
1. Release reset; hold all dones low. Required: init=1 for 1 cycle, then draw_map=1. At cycle 16 of S_DRAW_MAP, state goes to 2 (S_DRAW_LINK) and draw_timeout_err=1.
2. Full frame with done pulses 5 cycles after each draw entry and idle_done 10 cycles into S_IDLE. Required: strobe order map, link, enemies, idle, gen_move(1), check_collide(2), apply(1), move_enemies(1), draw_map. frame_count=1. draw_timeout_err=0.
3. Hold draw_map_done=1 continuously from reset. Required: S_DRAW_MAP lasts exactly 2 cycles; all draw states still visited in order.
4. Assert reset asynchronously mid-S_DRAW_LINK (between clock edges). Required: all strobes drop immediately, state_dbg=0, frame_count=0, draw_timeout_err cleared.
5. Pulse draw_enemies_done during S_DRAW_MAP and idle_done during S_COLLIDE. Required: no state change beyond normal sequencing.
6. Run 65536 frames with FRAME_W=16 and fast dones. Required: frame_count wraps to 0 with no other effect; exactly one strobe high every cycle.
